pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the architectural PC for the multicycle core and steps each instruction through FETCH/DECODE/EXEC/UPDATE.
//  Selects the next PC: sequential PC+2, taken branch, jump, call or return.
//  Handshakes with instruction memory and with the decode/execute control.
//  Sits between the control unit and the PC incrementer/instruction-memory datapath.
// PARAMETERS
//  PC_W       16       PC width in bits
//  RESET_PC   16'h0000 PC value loaded on reset
//  INSTR_B    2        PC increment in bytes (fixed instruction size)
//  RAS_DEPTH  4        return-address stack entries (used only with PC_SEQ_RAS_EN)
// PORTS
//  clk          in   1     single clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  fetch_req    out  1     instruction fetch request at address pc
//  fetch_ack    in   1     instruction word valid this cycle
//  ir_load      out  1     1-cycle pulse: latch instruction register
//  dec_done     in   1     decode complete; dec_type/br_taken/target valid
//  dec_type     in   3     0 SEQ, 1 BR, 2 JMP, 3 CALL, 4 RET, others = SEQ
//  br_taken     in   1     branch condition (dec_type==BR only)
//  target       in   PC_W  branch/jump/call target
//  ex_done      in   1     execute/memory/writeback complete
//  halt         in   1     stop after the current instruction
//  pc           out  PC_W  current PC
//  link_addr    out  PC_W  PC+INSTR_B of the current instruction (for register link)
//  halted       out  1     in HALT state
//  fault        out  1     sticky; in FAULT state
// BEHAVIOUR
//  Reset (async, immediate): pc=RESET_PC; state=FETCH; fetch_req=1 on the first clock edge after reset release; ir_load=0; halted=0; fault=0; stack/link cleared.
//  FETCH: fetch_req=1; on fetch_ack -> ir_load pulse in the same cycle, go to DECODE. fetch_req drops only on exit.
//  DECODE: wait for dec_done; capture dec_type, br_taken and target in the same cycle; go to EXEC.
//  EXEC: wait for ex_done; go to UPDATE.
//  UPDATE (1 cycle): pc <= next PC; go to HALT if halt=1 (sampled here), else FETCH.
//  Minimum of 4 cycles per instruction when fetch_ack, dec_done and ex_done are all high on first request.
//  Next PC: SEQ or untaken BR = pc+INSTR_B; taken BR/JMP/CALL = captured target; RET = popped address.
//  Arithmetic is modulo 2^PC_W: 0xFFFE+2 -> 0x0000; no flag.
//  A bit-0 set on any non-sequential next PC is a fault: pc is not updated, state -> FAULT.
//  FAULT: fetch_req=0, fault=1; held until reset. HALT: halted=1, fetch_req=0; held until reset.
//  halt asserted outside UPDATE has no effect until the next UPDATE.
//  Inputs (fetch_ack, dec_done, ex_done) asserted in a state that does not wait on them are ignored.
//  Reset mid-instruction discards captured decode info and any pending push/pop.
// CONFIGURATION
//  PC_SEQ_RAS_EN defined: RAS_DEPTH-entry return stack.
//   - CALL pushes pc+INSTR_B in UPDATE; RET pops.
//   - Push when full overwrites the oldest entry (circular); no fault.
//   - RET when empty -> FAULT.
//  PC_SEQ_RAS_EN undefined: single link register plus valid bit.
//   - CALL writes the link register; RET reads it and clears valid.
//   - RET with valid=0 -> FAULT.
// STRUCTURE
//  Package pc_seq_pkg: state enum (FETCH, DECODE, EXEC, UPDATE, HALT, FAULT); dec_type codes SEQ/BR/JMP/CALL/RET.
//  Sub-module pc_ret_stack (push, pop, push_data, pop_data, empty, full); instantiated only under PC_SEQ_RAS_EN.
//  PC+INSTR_B adder is inline.
// TESTING
//  1) Reset release, then 3 SEQ instructions with immediate acks -> pc 0000, 0002, 0004, 0006; 4 cycles per instruction.
//  2) BR with br_taken=1, target=0x0040 -> pc=0x0040; same with br_taken=0 -> pc+2.
//  3) pc=0xFFFE, SEQ -> pc=0x0000; JMP to target 0x0013 -> fault=1, pc unchanged, fetch_req=0.
//  4) CALL 0x0100 at pc=0x0010, then RET -> pc=0x0012.
//     With RAS: 5 nested CALLs then 5 RETs -> 4 correct returns, 5th RET faults.
//  5) fetch_ack delayed 3 cycles and ex_done delayed 2 cycles -> fetch_req held, ir_load single pulse, pc updates once.
//  6) halt pulsed in EXEC (ignored) vs. held high through UPDATE -> HALT; rst_n low during DECODE -> pc=RESET_PC immediately.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared constants for the multicycle PC sequencer: FSM state codes and decode type codes.
package pc_seq_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  localparam logic [2:0] DT_SEQ  = 3'd0;
  localparam logic [2:0] DT_BR   = 3'd1;
  localparam logic [2:0] DT_JMP  = 3'd2;
  localparam logic [2:0] DT_CALL = 3'd3;
  localparam logic [2:0] DT_RET  = 3'd4;

  // Unassigned decode codes behave as sequential instructions.
  function automatic logic [2:0] norm_dec_type(input logic [2:0] t);
    return (t > DT_RET) ? DT_SEQ : t;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    top_q;  // next slot to write
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    top_inc, top_dec;

  always_comb begin
    top_inc = (top_q == AW'(DEPTH - 1)) ? '0 : top_q + 1'b1;
    top_dec = (top_q == '0) ? AW'(DEPTH - 1) : top_q - 1'b1;
  end

  assign pop_data = mem_q[top_dec];
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      top_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      mem_q[top_q] <= push_data;
      top_q        <= top_inc;
      if (!full) cnt_q <= cnt_q + 1'b1;
    end else if (pop && !empty) begin
      top_q <= top_dec;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner stepping FETCH/DECODE/EXEC/UPDATE; next-PC select with call/return.
// Define PC_SEQ_RAS_EN for a RAS_DEPTH-entry return stack, otherwise a single link register.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     INSTR_B   = 2,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fetch_req,
  input  logic            fetch_ack,
  output logic            ir_load,
  input  logic            dec_done,
  input  logic [2:0]      dec_type,
  input  logic            br_taken,
  input  logic [PC_W-1:0] target,
  input  logic            ex_done,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] link_addr,
  output logic            halted,
  output logic            fault
);

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, nxt_pc, target_q, ret_addr;
  logic [2:0]      dtype_q;
  logic            taken_q, ret_ok;
  logic            nonseq, bad, push_req, pop_req, do_push, do_pop;

  assign pc        = pc_q;
  assign link_addr = pc_q + PC_W'(INSTR_B);
  assign fetch_req = (state_q == ST_FETCH);
  assign ir_load   = fetch_req & fetch_ack;
  assign halted    = (state_q == ST_HALT);
  assign fault     = (state_q == ST_FAULT);

  always_comb begin
    nxt_pc   = link_addr;
    nonseq   = 1'b0;
    bad      = 1'b0;
    push_req = 1'b0;
    pop_req  = 1'b0;
    case (dtype_q)
      DT_BR:   if (taken_q) begin nxt_pc = target_q; nonseq = 1'b1; end
      DT_JMP:  begin nxt_pc = target_q; nonseq = 1'b1; end
      DT_CALL: begin nxt_pc = target_q; nonseq = 1'b1; push_req = 1'b1; end
      DT_RET:  begin nxt_pc = ret_addr; nonseq = 1'b1; pop_req = 1'b1; bad = !ret_ok; end
      default: ;
    endcase
    if (nonseq && nxt_pc[0]) bad = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    case (state_q)
      ST_FETCH:  if (fetch_ack) state_d = ST_DECODE;
      ST_DECODE: if (dec_done) state_d = ST_EXEC;
      ST_EXEC:   if (ex_done) state_d = ST_UPDATE;
      ST_UPDATE: begin
        if (bad) begin
          state_d = ST_FAULT;
        end else begin
          pc_d    = nxt_pc;
          state_d = halt ? ST_HALT : ST_FETCH;
          do_push = push_req;
          do_pop  = pop_req;
        end
      end
      ST_HALT, ST_FAULT: ;
      default:   state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      dtype_q  <= DT_SEQ;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == ST_DECODE && dec_done) begin
        dtype_q  <= norm_dec_type(dec_type);
        taken_q  <= br_taken;
        target_q <= target;
      end
    end
  end

`ifdef PC_SEQ_RAS_EN
  logic ras_empty, ras_full_unused;

  pc_ret_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (PC_W)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (link_addr),
    .pop_data  (ret_addr),
    .empty     (ras_empty),
    .full      (ras_full_unused)
  );

  assign ret_ok = !ras_empty;
`else
  logic [PC_W-1:0] link_q;
  logic            link_vld_q;

  assign ret_addr = link_q;
  assign ret_ok   = link_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_q     <= '0;
      link_vld_q <= 1'b0;
    end else if (do_push) begin
      link_q     <= link_addr;
      link_vld_q <= 1'b1;
    end else if (do_pop) begin
      link_vld_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected post-UPDATE state is queued when an instruction
// is driven and compared once the UPDATE cycle has completed.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, fetch_ack, ir_load, dec_done, br_taken, ex_done, halt;
  logic        halted, fault;
  logic [2:0]  dec_type;
  logic [15:0] target, pc, link_addr;

  pc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_req (fetch_req),
    .fetch_ack (fetch_ack),
    .ir_load   (ir_load),
    .dec_done  (dec_done),
    .dec_type  (dec_type),
    .br_taken  (br_taken),
    .target    (target),
    .ex_done   (ex_done),
    .halt      (halt),
    .pc        (pc),
    .link_addr (link_addr),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        fault;
    logic        halted;
    logic        fetch_req;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          irl_total = 0;
  logic [15:0] m_pc;
  logic [15:0] m_link;
  logic        m_vld;
  logic        m_dead;
  logic [15:0] m_stk[$];

  always @(negedge clk) if (ir_load) irl_total++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [2:0] dt, input logic tk, input logic [15:0] tg,
                            input logic hlt, input int fd, input int ed);
    exp_t        e;
    logic [15:0] nxt;
    logic        nonseq, bad;
    nxt    = m_pc + 16'd2;
    nonseq = 1'b0;
    bad    = 1'b0;
    case (dt)
      3'd1: if (tk) begin nxt = tg; nonseq = 1'b1; end
      3'd2, 3'd3: begin nxt = tg; nonseq = 1'b1; end
      3'd4: begin
        nonseq = 1'b1;
`ifdef PC_SEQ_RAS_EN
        if (m_stk.size() == 0) bad = 1'b1;
        else nxt = m_stk[m_stk.size()-1];
`else
        if (!m_vld) bad = 1'b1;
        else nxt = m_link;
`endif
      end
      default: ;
    endcase
    if (nonseq && nxt[0]) bad = 1'b1;
    e.cycles = 4 + fd + ed;
    if (bad) begin
      e.pc = m_pc; e.fault = 1'b1; e.halted = 1'b0; e.fetch_req = 1'b0;
      m_dead = 1'b1;
    end else begin
      if (dt == 3'd3) begin
`ifdef PC_SEQ_RAS_EN
        if (m_stk.size() == 4) void'(m_stk.pop_front());
        m_stk.push_back(m_pc + 16'd2);
`else
        m_link = m_pc + 16'd2;
        m_vld  = 1'b1;
`endif
      end else if (dt == 3'd4) begin
`ifdef PC_SEQ_RAS_EN
        void'(m_stk.pop_back());
`else
        m_vld = 1'b0;
`endif
      end
      m_pc = nxt;
      e.pc = nxt; e.fault = 1'b0; e.halted = hlt; e.fetch_req = !hlt;
      if (hlt) m_dead = 1'b1;
    end
    sb.push_back(e);
  endtask

  // Drives one instruction from FETCH through UPDATE; entered and left at posedge+1.
  task automatic run_instr(input string tag, input logic [2:0] dt, input logic tk,
                           input logic [15:0] tg, input int fd, input int ed,
                           input logic hexec, input logic hlt);
    exp_t e;
    int   cyc = 0;
    int   irl0 = irl_total;
    model_step(dt, tk, tg, hlt, fd, ed);
    for (int i = 0; i < fd; i++) begin
      ex_done = 1'b1;  // ignored while fetching
      @(negedge clk);
      if (i == fd - 1) chk({tag, ".fetch_held"}, fetch_req, 1'b1);
      @(posedge clk); #1; cyc++;
    end
    ex_done = 1'b0; fetch_ack = 1'b1;
    @(posedge clk); #1; cyc++;
    fetch_ack = 1'b0;
    dec_done = 1'b1; dec_type = dt; br_taken = tk; target = tg;
    @(posedge clk); #1; cyc++;
    dec_done = 1'b0; dec_type = 3'd0; br_taken = 1'b0; target = 16'h0;
    halt = hexec;
    for (int i = 0; i < ed; i++) begin @(posedge clk); #1; cyc++; end
    ex_done = 1'b1;
    @(posedge clk); #1; cyc++;
    ex_done = 1'b0; halt = hlt;
    @(posedge clk); #1; cyc++;
    halt = 1'b0;
    e = sb.pop_front();
    chk({tag, ".pc"}, pc, e.pc);
    chk({tag, ".fault"}, fault, e.fault);
    chk({tag, ".halted"}, halted, e.halted);
    chk({tag, ".fetch_req"}, fetch_req, e.fetch_req);
    chk({tag, ".ir_load_n"}, irl_total - irl0, 1);
    chk({tag, ".cycles"}, cyc, e.cycles);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    chk({tag, ".pc"}, pc, 16'h0000);
    chk({tag, ".fault"}, fault, 1'b0);
    chk({tag, ".halted"}, halted, 1'b0);
    chk({tag, ".ir_load"}, ir_load, 1'b0);
    m_pc = 16'h0; m_vld = 1'b0; m_link = 16'h0; m_dead = 1'b0;
    m_stk.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".fetch_req"}, fetch_req, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; fetch_ack = 1'b0; dec_done = 1'b0; dec_type = 3'd0;
    br_taken = 1'b0; target = 16'h0; ex_done = 1'b0; halt = 1'b0;
    #3;
    do_reset("rst0");

    run_instr("seq0", 3'd0, 1'b0, 16'h0, 0, 0, 1'b0, 1'b0);
    run_instr("seq1", 3'd0, 1'b0, 16'h0, 0, 0, 1'b0, 1'b0);
    run_instr("seq2", 3'd0, 1'b0, 16'h0, 0, 0, 1'b0, 1'b0);
    chk("link_addr", link_addr, 16'h0008);
    run_instr("br_t", 3'd1, 1'b1, 16'h0040, 0, 0, 1'b0, 1'b0);
    run_instr("br_nt", 3'd1, 1'b0, 16'h0080, 0, 0, 1'b0, 1'b0);
    run_instr("dt7", 3'd7, 1'b1, 16'h0100, 0, 0, 1'b0, 1'b0);
    run_instr("slow", 3'd0, 1'b0, 16'h0, 3, 2, 1'b0, 1'b0);
    run_instr("hexec", 3'd0, 1'b0, 16'h0, 0, 1, 1'b1, 1'b0);

    run_instr("jmp10", 3'd2, 1'b0, 16'h0010, 0, 0, 1'b0, 1'b0);
    run_instr("call", 3'd3, 1'b0, 16'h0100, 0, 0, 1'b0, 1'b0);
    run_instr("ret", 3'd4, 1'b0, 16'h0, 0, 0, 1'b0, 1'b0);
    run_instr("ret_empty", 3'd4, 1'b0, 16'h0, 0, 0, 1'b0, 1'b0);
    do_reset("rst1");

    for (int i = 1; i <= 5; i++)
      run_instr("ncall", 3'd3, 1'b0, 16'(i * 16'h0100), 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      if (!m_dead) run_instr("nret", 3'd4, 1'b0, 16'h0, 0, 0, 1'b0, 1'b0);
    chk("nret.dead", fault, 1'b1);
    do_reset("rst2");

    run_instr("jmp_top", 3'd2, 1'b0, 16'hfffe, 0, 0, 1'b0, 1'b0);
    run_instr("wrap", 3'd0, 1'b0, 16'h0, 0, 0, 1'b0, 1'b0);
    run_instr("odd_jmp", 3'd2, 1'b0, 16'h0013, 0, 0, 1'b0, 1'b0);
    fetch_ack = 1'b1; dec_done = 1'b1; ex_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    fetch_ack = 1'b0; dec_done = 1'b0; ex_done = 1'b0;
    chk("fault_sticky", fault, 1'b1);
    chk("fault_pc", pc, 16'h0000);
    do_reset("rst3");

    run_instr("halt", 3'd0, 1'b0, 16'h0, 0, 0, 1'b0, 1'b1);
    fetch_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    fetch_ack = 1'b0;
    chk("halt_sticky", halted, 1'b1);
    chk("halt_pc", pc, 16'h0002);
    do_reset("rst4");

    run_instr("jmp80", 3'd2, 1'b0, 16'h0080, 0, 0, 1'b0, 1'b0);
    fetch_ack = 1'b1;
    @(posedge clk); #1;
    fetch_ack = 1'b0; dec_done = 1'b1; dec_type = 3'd2; target = 16'h0200;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_dec.pc", pc, 16'h0000);
    chk("rst_dec.fetch_req", fetch_req, 1'b1);
    dec_done = 1'b0; dec_type = 3'd0; target = 16'h0;
    m_pc = 16'h0; m_vld = 1'b0; m_dead = 1'b0;
    m_stk.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr("post_rst", 3'd0, 1'b0, 16'h0, 0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
